jtframe_dcrm: RTL and testbench

JTFRAME_DCRM -- requirements
Module: jtframe_dcrm

---
 rtl/jtframe_dcrm.sv | 75 +++++++
 tb/tb_jtframe_dcrm.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtframe_dcrm.sv
// DC-removal high-pass filter: subtracts a leaky running mean (time constant 2^DW samples)
// from each strobed input sample and saturates the result back to SW bits.
module jtframe_dcrm #(
    parameter int SW           = 8,
    parameter int DW           = 10,
    parameter int SIGNED_INPUT = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 sample,
    input  logic [SW-1:0]        din,
    output logic signed [SW-1:0] dout,
    output logic                 clip
);
    localparam int unsigned AW = SW + DW + 2;   // accumulator: DC estimate scaled by 2^DW
    localparam int unsigned MW = AW - DW;       // integer part of the estimate

    localparam logic signed [AW-1:0] SAT_HI = AW'((1 << (SW - 1)) - 1);
    localparam logic signed [AW-1:0] SAT_LO = ~SAT_HI;

    logic signed [AW-1:0] acc;
    logic signed [AW-1:0] acc_nxt;
    logic signed [SW:0]   x;
    logic signed [MW-1:0] mean;
    logic signed [AW-1:0] x_ext;
    logic signed [AW-1:0] mean_ext;
    logic signed [AW-1:0] diff;
    logic signed [SW-1:0] sat_c;
    logic                 sat_hit_c;

    // Input to signed SW+1-bit: offset-binary recentres by flipping the MSB
    generate
        if (SIGNED_INPUT != 0) begin : g_signed_in
            assign x = {din[SW-1], din};
        end else begin : g_offset_in
            assign x = {~din[SW-1], ~din[SW-1], din[SW-2:0]};
        end
    endgenerate

    // Filter arithmetic at full accumulator width; mean is floor(acc / 2^DW)
    always_comb begin
        mean     = MW'(acc >>> DW);
        x_ext    = AW'(x);
        mean_ext = AW'(mean);
        diff     = x_ext - mean_ext;
        acc_nxt  = acc + diff;
    end

    // Saturate x - mean to the SW-bit signed range
    always_comb begin
        sat_c     = diff[SW-1:0];
        sat_hit_c = 1'b0;
        if (diff > SAT_HI) begin
            sat_c     = SAT_HI[SW-1:0];
            sat_hit_c = 1'b1;
        end else if (diff < SAT_LO) begin
            sat_c     = SAT_LO[SW-1:0];
            sat_hit_c = 1'b1;
        end
    end

    // State advances only on the sample strobe; reset clears everything at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc  <= '0;
            dout <= '0;
            clip <= 1'b0;
        end else if (sample) begin
            acc  <= acc_nxt;
            dout <= sat_c;
            clip <= sat_hit_c;
        end
    end

endmodule

// File: tb/tb_jtframe_dcrm.sv
// Bench for jtframe_dcrm: offset-binary and two's-complement instances share stimulus
// and are checked against a floor-division reference model of the filter.
module tb_jtframe_dcrm;
    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              sample = 1'b0;
    logic [7:0]        din = 8'h00;
    logic signed [7:0] dout_u, dout_s;
    logic              clip_u, clip_s;

    int total = 0;
    int bad   = 0;

    longint acc_u = 0, acc_s = 0;
    int     eu = 0, es = 0;
    bit     cu = 1'b0, cs = 1'b0;

    always #5 clk = ~clk;

    jtframe_dcrm #(.SW(8), .DW(10), .SIGNED_INPUT(0)) u_dut (
        .clk(clk), .rst_n(rst_n), .sample(sample), .din(din), .dout(dout_u), .clip(clip_u)
    );
    jtframe_dcrm #(.SW(8), .DW(10), .SIGNED_INPUT(1)) s_dut (
        .clk(clk), .rst_n(rst_n), .sample(sample), .din(din), .dout(dout_s), .clip(clip_s)
    );

    function automatic longint floor_div(input longint a, input longint b);
        if (a >= 0) return a / b;
        return -((-a + b - 1) / b);
    endfunction

    function automatic void model(input longint acc_in, input logic [7:0] d, input bit sgn,
                                  output longint acc_out, output int y, output bit c);
        longint xv, mean, df;
        if (sgn) xv = longint'($signed(d));
        else     xv = longint'(d) - 128;
        mean    = floor_div(acc_in, 1024);
        df      = xv - mean;
        acc_out = acc_in + df;
        c = 1'b1;
        if (df > 127)       y = 127;
        else if (df < -128) y = -128;
        else begin
            y = int'(df);
            c = 1'b0;
        end
    endfunction

    // Caller is at a negedge; leaves sample high so repeated calls are back-to-back strobes
    task automatic strobe(input logic [7:0] d);
        din    = d;
        sample = 1'b1;
        @(negedge clk);
        model(acc_u, d, 1'b0, acc_u, eu, cu);
        model(acc_s, d, 1'b1, acc_s, es, cs);
    endtask

    task automatic idle(input int n);
        sample = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        sample = 1'b1;
        rst_n  = 1'b0;
        repeat (2) @(negedge clk);
        acc_u = 0; acc_s = 0;
        rst_n  = 1'b1;
        sample = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        sample = 1'b1;
        rst_n  = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (dout_u !== 8'sd0 || clip_u !== 1'b0 || dout_s !== 8'sd0 || clip_s !== 1'b0) begin
            bad++;
            $display("FAIL reset_hold: dout_u=%0d clip_u=%b dout_s=%0d clip_s=%b want 0/0", dout_u, clip_u, dout_s, clip_s);
        end
        acc_u = 0; acc_s = 0;
        rst_n  = 1'b1;
        sample = 1'b0;
        @(negedge clk);
        strobe(8'h80);
        sample = 1'b0;
        total++;
        if (int'(dout_u) != 0 || longint'(u_dut.acc) != 0) begin
            bad++;
            $display("FAIL reset_mid_in: dout=%0d acc=%0d want 0 0", dout_u, u_dut.acc);
        end
        total++;
        if (int'(dout_s) != es || clip_s !== cs) begin
            bad++;
            $display("FAIL reset_mid_in_s: dout=%0d clip=%b want %0d %b", dout_s, clip_s, es, cs);
        end
        idle(1);
    endtask

    task automatic test_step();
        int prev;
        bit mono_ok;
        do_reset();
        strobe(8'hFF);
        total++;
        if (int'(dout_u) != 127 || clip_u !== 1'b0) begin
            bad++;
            $display("FAIL step_first: dout=%0d clip=%b want 127 0", dout_u, clip_u);
        end
        prev    = int'(dout_u);
        mono_ok = 1'b1;
        for (int i = 1; i < 8192; i++) begin
            strobe(8'hFF);
            if (int'(dout_u) > prev) mono_ok = 1'b0;
            prev = int'(dout_u);
        end
        sample = 1'b0;
        total++;
        if (!mono_ok) begin
            bad++;
            $display("FAIL step_monotonic: dout rose during decay, last=%0d", dout_u);
        end
        total++;
        if (int'(dout_u) > 1 || int'(dout_u) != eu) begin
            bad++;
            $display("FAIL step_settled: dout=%0d want %0d (<=1)", dout_u, eu);
        end
        total++;
        if (longint'(u_dut.acc) != acc_u) begin
            bad++;
            $display("FAIL step_acc: acc=%0d want %0d", u_dut.acc, acc_u);
        end
        idle(1);
    endtask

    task automatic test_neg_fullscale();
        do_reset();
        strobe(8'h00);
        sample = 1'b0;
        total++;
        if (int'(dout_u) != -128 || clip_u !== 1'b0) begin
            bad++;
            $display("FAIL neg_full: dout=%0d clip=%b want -128 0", dout_u, clip_u);
        end
        idle(1);
    endtask

    task automatic test_clip();
        int  n;
        bit  seq_ok;
        do_reset();
        for (int i = 0; i < 16384; i++) strobe(8'h00);
        strobe(8'hFF);
        total++;
        if (int'(dout_u) != 127 || clip_u !== 1'b1) begin
            bad++;
            $display("FAIL clip_first: dout=%0d clip=%b want 127 1", dout_u, clip_u);
        end
        n      = 0;
        seq_ok = 1'b1;
        while (cu && n < 4096) begin
            strobe(8'hFF);
            if (int'(dout_u) != eu || clip_u !== cu) seq_ok = 1'b0;
            n++;
        end
        sample = 1'b0;
        total++;
        if (!seq_ok) begin
            bad++;
            $display("FAIL clip_seq: dout=%0d clip=%b want %0d %b", dout_u, clip_u, eu, cu);
        end
        total++;
        if (cu || clip_u !== 1'b0 || n == 0) begin
            bad++;
            $display("FAIL clip_release: clip=%b after %0d strobes want 0 (model clip=%b)", clip_u, n, cu);
        end
        idle(1);
    endtask

    task automatic test_gating();
        logic signed [7:0]  hd;
        logic               hc;
        logic signed [19:0] ha;
        do_reset();
        for (int i = 0; i < 10; i++) strobe(8'($urandom_range(0, 255)));
        sample = 1'b0;
        hd = dout_u; hc = clip_u; ha = u_dut.acc;
        for (int i = 0; i < 20; i++) begin
            din = 8'($urandom);
            @(negedge clk);
        end
        total++;
        if (dout_u !== hd || clip_u !== hc || u_dut.acc !== ha || int'(dout_u) != eu) begin
            bad++;
            $display("FAIL gating: dout=%0d clip=%b acc=%0d want %0d %b %0d", dout_u, clip_u, u_dut.acc, hd, hc, ha);
        end
    endtask

    task automatic test_signed();
        do_reset();
        strobe(8'h7F);
        sample = 1'b0;
        total++;
        if (int'(dout_s) != 127 || clip_s !== 1'b0 || int'(dout_u) != -1) begin
            bad++;
            $display("FAIL signed_pos: dout_s=%0d clip_s=%b dout_u=%0d want 127 0 -1", dout_s, clip_s, dout_u);
        end
        do_reset();
        strobe(8'h80);
        sample = 1'b0;
        total++;
        if (int'(dout_s) != -128 || clip_s !== 1'b0) begin
            bad++;
            $display("FAIL signed_neg: dout_s=%0d clip_s=%b want -128 0", dout_s, clip_s);
        end
        idle(1);
    endtask

    task automatic test_midstream_reset();
        do_reset();
        for (int i = 0; i < 100; i++) strobe(8'hFF);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (dout_u !== 8'sd0 || clip_u !== 1'b0 || u_dut.acc !== 20'sd0) begin
            bad++;
            $display("FAIL midreset_async: dout=%0d clip=%b acc=%0d want 0 0 0", dout_u, clip_u, u_dut.acc);
        end
        @(negedge clk);
        @(negedge clk);
        total++;
        if (dout_u !== 8'sd0 || dout_s !== 8'sd0) begin
            bad++;
            $display("FAIL midreset_dominates: dout_u=%0d dout_s=%0d want 0", dout_u, dout_s);
        end
        acc_u = 0; acc_s = 0;
        rst_n  = 1'b1;
        sample = 1'b0;
        @(negedge clk);
        strobe(8'hFF);
        sample = 1'b0;
        total++;
        if (int'(dout_u) != 127 || int'(dout_s) != -1) begin
            bad++;
            $display("FAIL midreset_restart: dout_u=%0d dout_s=%0d want 127 -1", dout_u, dout_s);
        end
        idle(1);
    endtask

    task automatic test_random();
        int errs;
        errs = 0;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            // biased DC offset so the tracker has something to remove
            strobe(8'($urandom_range(0, 127) + 96));
            total++;
            if (int'(dout_u) != eu || clip_u !== cu || int'(dout_s) != es || clip_s !== cs) begin
                bad++;
                errs++;
                if (errs <= 5)
                    $display("FAIL random[%0d]: u=%0d/%b s=%0d/%b want %0d/%b %0d/%b",
                             i, dout_u, clip_u, dout_s, clip_s, eu, cu, es, cs);
            end
        end
        sample = 1'b0;
        total++;
        if (longint'(u_dut.acc) != acc_u || longint'(s_dut.acc) != acc_s) begin
            bad++;
            $display("FAIL random_acc: acc_u=%0d acc_s=%0d want %0d %0d", u_dut.acc, s_dut.acc, acc_u, acc_s);
        end
        idle(1);
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_step();
        test_neg_fullscale();
        test_clip();
        test_gating();
        test_signed();
        test_midstream_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
